// File: rtl/store_align_queue.sv
// rtl/store_align_queue.sv - store alignment, byte-enable encoding and in-order write buffer
//
// Ports:
//   clk, reset               clock (rising edge), asynchronous active-high reset
//   st_valid, st_op          store request from MEM (01=SW, 10=SH, 11=SB, 00=none)
//   st_addr, st_wdata        byte address and register data of the store
//   st_ready                 buffer has a free slot this cycle
//   st_exc                   misaligned store this cycle (combinational)
//   mem_req, mem_addr,       registered write request towards the bus: word address,
//   mem_byteen, mem_wdata    byte enables and lane-replicated data
//   mem_ack                  bus accepted the presented write
//   ld_addr, ld_conflict     load address in MEM; a buffered store hits the same word
//   buf_empty, buf_count     occupancy, including the entry being presented
module store_align_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  input  logic [1:0]       st_op,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_wdata,
  output logic             st_ready,
  output logic             st_exc,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  output logic [3:0]       mem_byteen,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ack,
  input  logic [31:0]      ld_addr,
  output logic             ld_conflict,
  output logic             buf_empty,
  output logic [CNT_W-1:0] buf_count
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic {IDLE, BUSY} state_t;

  logic [29:0]      q_addr [DEPTH];
  logic [3:0]       q_be   [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic [DEPTH-1:0] q_vld;

  logic [PTR_W-1:0] rd_ptr, wr_ptr, nxt_ptr;
  logic [CNT_W-1:0] count;
  state_t           state;

  logic             misaligned;
  logic             push, pop;
  logic [3:0]       enc_be;
  logic [31:0]      enc_data;

  // Low address bits of the load are irrelevant to a word-granular hazard check.
  logic unused_ld_bits;
  assign unused_ld_bits = &{1'b0, ld_addr[1:0]};

  assign misaligned = ((st_op == 2'b01) && (st_addr[1:0] != 2'b00)) ||
                      ((st_op == 2'b10) && st_addr[0]);
  assign st_exc     = st_valid & misaligned;

  // Ready is based on the registered count only, so an ack in the same cycle
  // never opens a slot early; this keeps st_ready free of a mem_ack path.
  assign st_ready   = (count < CNT_W'(DEPTH));
  assign push       = st_valid & (st_op != 2'b00) & ~st_exc & st_ready;
  assign pop        = (state == BUSY) & mem_ack;
  assign nxt_ptr    = rd_ptr + PTR_W'(1);

  assign buf_count  = count;
  assign buf_empty  = (count == '0);

  always_comb begin
    enc_be   = 4'b1111;
    enc_data = st_wdata;
    case (st_op)
      2'b10: begin
        enc_be   = st_addr[1] ? 4'b1100 : 4'b0011;
        enc_data = {2{st_wdata[15:0]}};
      end
      2'b11: begin
        enc_be   = 4'b0001 << st_addr[1:0];
        enc_data = {4{st_wdata[7:0]}};
      end
      default: ;
    endcase
  end

  // The in-flight entry stays valid until acked, so it is covered here too.
  always_comb begin
    ld_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_vld[i] && (q_addr[i] == ld_addr[31:2])) begin
        ld_conflict = 1'b1;
      end
    end
  end

  // Payload storage needs no reset; q_vld qualifies every slot.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= st_addr[31:2];
      q_be[wr_ptr]   <= enc_be;
      q_data[wr_ptr] <= enc_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      q_vld      <= '0;
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_byteen <= '0;
      mem_wdata  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase

      // A push never lands on the popped slot: push needs count<DEPTH and a
      // pop needs count>=1, so wr_ptr==rd_ptr cannot coincide with both.
      if (pop) begin
        q_vld[rd_ptr] <= 1'b0;
      end
      if (push) begin
        q_vld[wr_ptr] <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (count != '0) begin
            mem_req    <= 1'b1;
            mem_addr   <= {q_addr[rd_ptr], 2'b00};
            mem_byteen <= q_be[rd_ptr];
            mem_wdata  <= q_data[rd_ptr];
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            rd_ptr <= nxt_ptr;
            // A same-cycle push is not considered; it is picked up from IDLE.
            if (count > CNT_W'(1)) begin
              mem_addr   <= {q_addr[nxt_ptr], 2'b00};
              mem_byteen <= q_be[nxt_ptr];
              mem_wdata  <= q_data[nxt_ptr];
            end else begin
              mem_req <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_align_queue.sv
// tb/tb_store_align_queue.sv - table-driven directed bench for store_align_queue
module tb_store_align_queue;

  localparam logic [1:0]  NO = 2'b00;
  localparam logic [1:0]  SW = 2'b01;
  localparam logic [1:0]  SH = 2'b10;
  localparam logic [1:0]  SB = 2'b11;
  localparam logic [31:0] L  = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [1:0]  st_op;
  logic [31:0] st_addr;
  logic [31:0] st_wdata;
  logic        st_ready;
  logic        st_exc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] ld_addr;
  logic        ld_conflict;
  logic        buf_empty;
  logic [2:0]  buf_count;

  store_align_queue #(.DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_op(st_op), .st_addr(st_addr), .st_wdata(st_wdata),
    .st_ready(st_ready), .st_exc(st_exc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_byteen(mem_byteen), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .ld_addr(ld_addr), .ld_conflict(ld_conflict),
    .buf_empty(buf_empty), .buf_count(buf_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        ack;
    logic [31:0] ld;
    logic        e_rdy;
    logic        e_exc;
    logic        e_req;
    logic        chk_mem;
    logic [31:0] e_maddr;
    logic [3:0]  e_be;
    logic [31:0] e_mwd;
    logic        e_conf;
    logic [2:0]  e_cnt;
  } vec_t;

  localparam int NV = 33;
  vec_t vecs [NV];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mk(
    input logic v, input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd,
    input logic ack, input logic [31:0] ld,
    input logic rdy, input logic exc, input logic req, input logic cm,
    input logic [31:0] maddr, input logic [3:0] be, input logic [31:0] mwd,
    input logic conf, input logic [2:0] cnt);
    vec_t r;
    r.v = v; r.op = op; r.addr = addr; r.wd = wd; r.ack = ack; r.ld = ld;
    r.e_rdy = rdy; r.e_exc = exc; r.e_req = req; r.chk_mem = cm;
    r.e_maddr = maddr; r.e_be = be; r.e_mwd = mwd; r.e_conf = conf; r.e_cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input logic ack, input logic [31:0] ld);
    st_valid = v; st_op = op; st_addr = addr; st_wdata = wd; mem_ack = ack; ld_addr = ld;
  endtask

  initial begin
    // SB 0x1003 held while mem_ack=0, then acked
    vecs[0]  = mk(1, SB, 32'h1003, 32'hA5, 0, L,  1, 0, 0, 1, 32'h0, 4'b0000, 32'h0, 0, 0);
    vecs[1]  = mk(0, NO, 32'h0, 32'h0, 0, L,      1, 0, 0, 0, 32'h0, 4'b0000, 32'h0, 0, 1);
    vecs[2]  = mk(0, NO, 32'h0, 32'h0, 0, L,      1, 0, 1, 1, 32'h1000, 4'b1000, 32'hA5A5A5A5, 0, 1);
    vecs[3]  = mk(0, NO, 32'h0, 32'h0, 0, L,      1, 0, 1, 1, 32'h1000, 4'b1000, 32'hA5A5A5A5, 0, 1);
    vecs[4]  = mk(0, NO, 32'h0, 32'h0, 1, L,      1, 0, 1, 1, 32'h1000, 4'b1000, 32'hA5A5A5A5, 0, 1);
    vecs[5]  = mk(0, NO, 32'h0, 32'h0, 0, L,      1, 0, 0, 1, 32'h1000, 4'b1000, 32'hA5A5A5A5, 0, 0);
    // SH then SW with mem_ack held high: back-to-back, ack while idle ignored
    vecs[6]  = mk(1, SH, 32'h1002, 32'h1234BEEF, 1, L, 1, 0, 0, 0, 32'h0, 4'b0, 32'h0, 0, 0);
    vecs[7]  = mk(1, SW, 32'h1004, 32'hCAFEF00D, 1, L, 1, 0, 0, 0, 32'h0, 4'b0, 32'h0, 0, 1);
    vecs[8]  = mk(0, NO, 32'h0, 32'h0, 1, L,      1, 0, 1, 1, 32'h1000, 4'b1100, 32'hBEEFBEEF, 0, 2);
    vecs[9]  = mk(0, NO, 32'h0, 32'h0, 1, L,      1, 0, 1, 1, 32'h1004, 4'b1111, 32'hCAFEF00D, 0, 1);
    vecs[10] = mk(0, NO, 32'h0, 32'h0, 1, L,      1, 0, 0, 1, 32'h1004, 4'b1111, 32'hCAFEF00D, 0, 0);
    // misaligned SW/SH, and op=00 with st_valid
    vecs[11] = mk(1, SW, 32'h1001, 32'h11111111, 0, L, 1, 1, 0, 0, 32'h0, 4'b0, 32'h0, 0, 0);
    vecs[12] = mk(1, SH, 32'h1003, 32'h22222222, 0, L, 1, 1, 0, 0, 32'h0, 4'b0, 32'h0, 0, 0);
    vecs[13] = mk(1, NO, 32'h1001, 32'h33333333, 0, L, 1, 0, 0, 0, 32'h0, 4'b0, 32'h0, 0, 0);
    vecs[14] = mk(0, NO, 32'h0, 32'h0, 0, L,      1, 0, 0, 1, 32'h1004, 4'b1111, 32'hCAFEF00D, 0, 0);
    // fill with four SBs, 5th rejected, pop does not free a slot same cycle
    vecs[15] = mk(1, SB, 32'h3000, 32'h11, 0, L,  1, 0, 0, 0, 32'h0, 4'b0, 32'h0, 0, 0);
    vecs[16] = mk(1, SB, 32'h3001, 32'h22, 0, L,  1, 0, 0, 0, 32'h0, 4'b0, 32'h0, 0, 1);
    vecs[17] = mk(1, SB, 32'h3002, 32'h33, 0, L,  1, 0, 1, 1, 32'h3000, 4'b0001, 32'h11111111, 0, 2);
    vecs[18] = mk(1, SB, 32'h3003, 32'h44, 0, L,  1, 0, 1, 1, 32'h3000, 4'b0001, 32'h11111111, 0, 3);
    vecs[19] = mk(1, SB, 32'h3000, 32'h55, 0, L,  0, 0, 1, 1, 32'h3000, 4'b0001, 32'h11111111, 0, 4);
    vecs[20] = mk(0, NO, 32'h0, 32'h0, 0, L,      0, 0, 1, 1, 32'h3000, 4'b0001, 32'h11111111, 0, 4);
    vecs[21] = mk(1, SB, 32'h3000, 32'h66, 1, L,  0, 0, 1, 1, 32'h3000, 4'b0001, 32'h11111111, 0, 4);
    vecs[22] = mk(0, NO, 32'h0, 32'h0, 0, L,      1, 0, 1, 1, 32'h3000, 4'b0010, 32'h22222222, 0, 3);
    vecs[23] = mk(0, NO, 32'h0, 32'h0, 1, L,      1, 0, 1, 1, 32'h3000, 4'b0010, 32'h22222222, 0, 3);
    vecs[24] = mk(0, NO, 32'h0, 32'h0, 1, L,      1, 0, 1, 1, 32'h3000, 4'b0100, 32'h33333333, 0, 2);
    vecs[25] = mk(0, NO, 32'h0, 32'h0, 1, L,      1, 0, 1, 1, 32'h3000, 4'b1000, 32'h44444444, 0, 1);
    vecs[26] = mk(0, NO, 32'h0, 32'h0, 0, L,      1, 0, 0, 1, 32'h3000, 4'b1000, 32'h44444444, 0, 0);
    // load/store word conflict
    vecs[27] = mk(1, SW, 32'h2008, 32'hDEADBEEF, 0, 32'h200B, 1, 0, 0, 0, 32'h0, 4'b0, 32'h0, 0, 0);
    vecs[28] = mk(0, NO, 32'h0, 32'h0, 0, 32'h200B, 1, 0, 0, 0, 32'h0, 4'b0, 32'h0, 1, 1);
    vecs[29] = mk(0, NO, 32'h0, 32'h0, 0, 32'h200C, 1, 0, 1, 1, 32'h2008, 4'b1111, 32'hDEADBEEF, 0, 1);
    vecs[30] = mk(0, NO, 32'h0, 32'h0, 0, 32'h200B, 1, 0, 1, 1, 32'h2008, 4'b1111, 32'hDEADBEEF, 1, 1);
    vecs[31] = mk(0, NO, 32'h0, 32'h0, 1, 32'h200B, 1, 0, 1, 1, 32'h2008, 4'b1111, 32'hDEADBEEF, 1, 1);
    vecs[32] = mk(0, NO, 32'h0, 32'h0, 0, 32'h200B, 1, 0, 0, 1, 32'h2008, 4'b1111, 32'hDEADBEEF, 0, 0);

    reset = 1'b1;
    drive(0, NO, 32'h0, 32'h0, 0, L);
    #1;
    chk("rst.req",    {31'b0, mem_req},    32'd0);
    chk("rst.count",  {29'b0, buf_count},  32'd0);
    chk("rst.empty",  {31'b0, buf_empty},  32'd1);
    chk("rst.ready",  {31'b0, st_ready},   32'd1);
    chk("rst.addr",   mem_addr,            32'h0);
    chk("rst.byteen", {28'b0, mem_byteen}, 32'h0);
    chk("rst.wdata",  mem_wdata,           32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].op, vecs[i].addr, vecs[i].wd, vecs[i].ack, vecs[i].ld);
      #1;
      chk($sformatf("v%0d.ready", i), {31'b0, st_ready},    {31'b0, vecs[i].e_rdy});
      chk($sformatf("v%0d.exc", i),   {31'b0, st_exc},      {31'b0, vecs[i].e_exc});
      chk($sformatf("v%0d.req", i),   {31'b0, mem_req},     {31'b0, vecs[i].e_req});
      chk($sformatf("v%0d.conf", i),  {31'b0, ld_conflict}, {31'b0, vecs[i].e_conf});
      chk($sformatf("v%0d.count", i), {29'b0, buf_count},   {29'b0, vecs[i].e_cnt});
      chk($sformatf("v%0d.empty", i), {31'b0, buf_empty},   {31'b0, (vecs[i].e_cnt == 3'd0)});
      if (vecs[i].chk_mem) begin
        chk($sformatf("v%0d.addr", i),   mem_addr,            vecs[i].e_maddr);
        chk($sformatf("v%0d.byteen", i), {28'b0, mem_byteen}, {28'b0, vecs[i].e_be});
        chk($sformatf("v%0d.wdata", i),  mem_wdata,           vecs[i].e_mwd);
      end
    end

    // Asynchronous reset while BUSY with two entries
    @(negedge clk); drive(1, SW, 32'h4000, 32'h01010101, 0, L);
    @(negedge clk); drive(1, SW, 32'h4004, 32'h02020202, 0, L);
    @(negedge clk); drive(0, NO, 32'h0, 32'h0, 0, L);
    #1;
    chk("mid.req_before",   {31'b0, mem_req},   32'd1);
    chk("mid.count_before", {29'b0, buf_count}, 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("mid.req",    {31'b0, mem_req},    32'd0);
    chk("mid.count",  {29'b0, buf_count},  32'd0);
    chk("mid.empty",  {31'b0, buf_empty},  32'd1);
    chk("mid.ready",  {31'b0, st_ready},   32'd1);
    chk("mid.addr",   mem_addr,            32'h0);
    chk("mid.byteen", {28'b0, mem_byteen}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    mem_ack = 1'b1;
    @(negedge clk);
    #1;
    chk("stray.req",   {31'b0, mem_req},   32'd0);
    chk("stray.count", {29'b0, buf_count}, 32'd0);
    drive(1, SB, 32'h5002, 32'h7E, 0, L);
    @(negedge clk); drive(0, NO, 32'h0, 32'h0, 0, L);
    #1;
    chk("post.count", {29'b0, buf_count}, 32'd1);
    chk("post.req0",  {31'b0, mem_req},   32'd0);
    @(negedge clk);
    #1;
    chk("post.req",    {31'b0, mem_req},    32'd1);
    chk("post.addr",   mem_addr,            32'h5000);
    chk("post.byteen", {28'b0, mem_byteen}, 32'h4);
    chk("post.wdata",  mem_wdata,           32'h7E7E7E7E);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("post.req_done", {31'b0, mem_req},   32'd0);
    chk("post.empty",    {31'b0, buf_empty}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
